imm_encoder: RTL and testbench

//  Inverse of the decode-side immediate generator. Packs a register/immediate request into RV32I instruction words.

---
 rtl/riscv_enc_pkg.sv | 60 ++++++
 rtl/imm_range_chk.sv | 24 ++
 rtl/imm_encoder.sv | 152 +++++++++++++++
 tb/tb_imm_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared encoding vocabulary for the instruction builder: request formats,
// FSM states, base opcodes and the per-format field packers.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_B  = 3'd2,
    FMT_U  = 3'd3,
    FMT_J  = 3'd4,
    FMT_LI = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_LUI  = 2'd2,
    S_ADDI = 2'd3
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Each packer takes only the immediate bits its format can carry, so the
  // caller decides the truncation explicitly.
  function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:12] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Decides whether an immediate fits the format it is being packed into.
module imm_range_chk
  import riscv_enc_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [31:0] imm_i,
  output logic        err_o
);

  // Sign-extension checks: every bit above the field's top bit must match
  // the sign bit; branch/jump offsets must also be halfword aligned.
  always_comb begin
    err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: err_o = (imm_i[31:11] != {21{imm_i[31]}});
      FMT_B:        err_o = (imm_i[31:12] != {20{imm_i[31]}}) || imm_i[0];
      FMT_J:        err_o = (imm_i[31:20] != {12{imm_i[31]}}) || imm_i[0];
      FMT_U:        err_o = (imm_i[11:0] != 12'd0);
      FMT_LI:       err_o = 1'b0;
      default:      err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Packs register/immediate requests into RV32I words and streams them out;
// LI is split into LUI+ADDI over two beats when needed.
module imm_encoder
  import riscv_enc_pkg::*;
#(
  parameter bit LI_OPT = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_fmt,
  input  logic [6:0]       req_opcode,
  input  logic [2:0]       req_funct3,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic             out_last,
  output logic [CNT_W-1:0] word_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      addi_q, addi_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fmt_e        fmt;
  logic        chk_err;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [31:0] lui_word, addi_rd_word, addi_x0_word;
  logic [31:0] enc_word;
  logic        enc_last, enc_two;
  logic        handoff;

  assign fmt = fmt_e'(req_fmt);

  imm_range_chk u_chk (
    .fmt_i (fmt),
    .imm_i (req_imm),
    .err_o (chk_err)
  );

  // Adding 0x800 before dropping the low 12 bits only carries into bit 12
  // when imm[11] is set, so the rounding is a 20-bit increment.
  assign li_hi        = req_imm[31:12] + {19'd0, req_imm[11]};
  assign li_lo        = req_imm[11:0];
  assign lui_word     = pack_u(li_hi, req_rd, OPC_LUI);
  assign addi_rd_word = pack_i(li_lo, req_rd, 3'b000, req_rd, OPC_OPIMM);
  assign addi_x0_word = pack_i(li_lo, 5'd0, 3'b000, req_rd, OPC_OPIMM);

  // Encode the incoming request into its first word and note whether a
  // second (ADDI) beat has to follow.
  always_comb begin
    enc_word = '0;
    enc_last = 1'b1;
    enc_two  = 1'b0;
    case (fmt)
      FMT_I: enc_word = pack_i(req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode);
      FMT_S: enc_word = pack_s(req_imm[11:0], req_rs2, req_rs1, req_funct3, req_opcode);
      FMT_B: enc_word = pack_b(req_imm[12:1], req_rs2, req_rs1, req_funct3, req_opcode);
      FMT_U: enc_word = pack_u(req_imm[31:12], req_rd, req_opcode);
      FMT_J: enc_word = pack_j(req_imm[20:1], req_rd, req_opcode);
      FMT_LI: begin
        if (LI_OPT && (li_hi == 20'd0)) begin
          enc_word = addi_x0_word;
        end else if (LI_OPT && (li_lo == 12'd0)) begin
          enc_word = lui_word;
        end else begin
          enc_word = lui_word;
          enc_last = 1'b0;
          enc_two  = 1'b1;
        end
      end
      default: enc_word = '0;
    endcase
  end

  assign handoff = out_valid && out_ready;

  // Next-state logic: accept only when idle, hold the word under
  // backpressure, and swap in the stored ADDI right after the LUI leaves.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addi_d  = addi_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (handoff && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          instr_d = enc_word;
          err_d   = chk_err;
          last_d  = enc_last;
          addi_d  = addi_rd_word;
          state_d = enc_two ? S_LUI : S_ONE;
        end
      end
      S_ONE, S_ADDI: begin
        if (out_ready) state_d = S_IDLE;
      end
      S_LUI: begin
        if (out_ready) begin
          instr_d = addi_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
          state_d = S_ADDI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending ADDI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      addi_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addi_q  <= addi_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign out_valid = (state_q != S_IDLE);
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_last  = last_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench: two encoders (optimised LI with wide counter, plain LI
// with a 3-bit counter) share request data; expected words are queued at
// acceptance and popped by a monitor on every handoff.
module tb_imm_encoder;
  import riscv_enc_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValidA, reqValidB, reqReadyA, reqReadyB;
  logic [2:0]  reqFmt;
  logic [6:0]  reqOpcode;
  logic [2:0]  reqFunct3;
  logic [4:0]  reqRd, reqRs1, reqRs2;
  logic [31:0] reqImm;
  logic        outReady;
  logic        outValidA, outValidB, outErrA, outErrB, outLastA, outLastB;
  logic [31:0] outInstrA, outInstrB;
  logic [15:0] wordCntA;
  logic [2:0]  wordCntB;

  exp_t qA[$];
  exp_t qB[$];
  int   nCompared = 0;
  int   nFailed   = 0;
  int   modelCnt[2];
  int   satMax[2] = '{65535, 7};
  bit   held[2];
  exp_t heldWord[2];
  int   stallLeft = 0;
  bit   randReady = 1'b0;
  logic [6:0] opcTable[8] = '{OPC_LUI, OPC_OPIMM, OPC_LOAD, OPC_STORE,
                              OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM};

  always #5 clk = ~clk;

  imm_encoder #(.LI_OPT(1'b1), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValidA), .req_ready(reqReadyA),
    .req_fmt(reqFmt), .req_opcode(reqOpcode), .req_funct3(reqFunct3),
    .req_rd(reqRd), .req_rs1(reqRs1), .req_rs2(reqRs2), .req_imm(reqImm),
    .out_valid(outValidA), .out_ready(outReady), .out_instr(outInstrA),
    .out_err(outErrA), .out_last(outLastA), .word_cnt(wordCntA)
  );

  imm_encoder #(.LI_OPT(1'b0), .CNT_W(3)) dutB (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValidB), .req_ready(reqReadyB),
    .req_fmt(reqFmt), .req_opcode(reqOpcode), .req_funct3(reqFunct3),
    .req_rd(reqRd), .req_rs1(reqRs1), .req_rs2(reqRs2), .req_imm(reqImm),
    .out_valid(outValidB), .out_ready(outReady), .out_instr(outInstrB),
    .out_err(outErrB), .out_last(outLastB), .word_cnt(wordCntB)
  );

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushOne(input bit sel, input logic [31:0] w, input logic err, input logic last);
    exp_t e;
    e.instr = w;
    e.err   = err;
    e.last  = last;
    if (sel) qB.push_back(e);
    else     qA.push_back(e);
  endtask

  // Reference model: builds words from field positions with shifts/masks and
  // judges range from the signed value of the immediate.
  task automatic pushExpected(input bit sel, input logic [2:0] fmt, input logic [6:0] op,
                              input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w, hi, lo, base, lui, addi;
    int s;
    bit liOpt;
    s     = $signed(imm);
    liOpt = !sel;
    base  = (32'(rd) << 7) | 32'(op);
    case (fmt)
      FMT_I: pushOne(sel, ((imm & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base,
                     !(s >= -2048 && s <= 2047), 1'b1);
      FMT_S: begin
        w = (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((imm & 32'h1f) << 7) | 32'(op);
        pushOne(sel, w, !(s >= -2048 && s <= 2047), 1'b1);
      end
      FMT_B: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
        pushOne(sel, w, !(s >= -4096 && s <= 4095) || (imm % 2 != 0), 1'b1);
      end
      FMT_U: pushOne(sel, (imm & 32'hfffff000) | base, (imm % 4096) != 0, 1'b1);
      FMT_J: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12) | base;
        pushOne(sel, w, !(s >= -(1 << 20) && s <= (1 << 20) - 1) || (imm % 2 != 0), 1'b1);
      end
      FMT_LI: begin
        hi   = (imm + 32'h800) >> 12;
        lo   = imm & 32'hfff;
        lui  = (hi << 12) | (32'(rd) << 7) | 32'h37;
        addi = (lo << 20) | (32'(rd) << 7) | 32'h13;
        if (liOpt && hi == 0)      pushOne(sel, addi, 1'b0, 1'b1);
        else if (liOpt && lo == 0) pushOne(sel, lui, 1'b0, 1'b1);
        else begin
          pushOne(sel, lui, 1'b0, 1'b0);
          pushOne(sel, addi | (32'(rd) << 15), 1'b0, 1'b1);
        end
      end
      default: pushOne(sel, 32'h0, 1'b1, 1'b1);
    endcase
  endtask

  task automatic applyStimulus(input bit sel, input logic [2:0] fmt, input logic [6:0] op,
                               input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    reqFmt = fmt; reqOpcode = op; reqFunct3 = f3;
    reqRd = rd; reqRs1 = rs1; reqRs2 = rs2; reqImm = imm;
    if (sel) reqValidB = 1'b1;
    else     reqValidA = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((sel ? reqReadyB : reqReadyA) && rst_n) begin
        pushExpected(sel, fmt, op, f3, rd, rs1, rs2, imm);
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      nCompared++;
      nFailed++;
      $display("[TB] FAIL accept_timeout: got no req_ready, expected acceptance within 300 cycles");
    end
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    reqValidB = 1'b0;
  endtask

  task automatic checkOutput(input bit sel, input bit rstEdge);
    logic v, rr;
    exp_t act, e;
    logic [31:0] cnt;
    string tag;
    tag        = sel ? "B" : "A";
    v          = sel ? outValidB : outValidA;
    rr         = sel ? reqReadyB : reqReadyA;
    act.instr  = sel ? outInstrB : outInstrA;
    act.err    = sel ? outErrB : outErrA;
    act.last   = sel ? outLastB : outLastA;
    cnt        = sel ? 32'(wordCntB) : 32'(wordCntA);
    if (rstEdge) begin
      checkEq({tag, "_rst_valid"}, 32'(v), 32'd0);
      checkEq({tag, "_rst_instr"}, act.instr, 32'd0);
      checkEq({tag, "_rst_err_last"}, {30'd0, act.err, act.last}, 32'd0);
      checkEq({tag, "_rst_word_cnt"}, cnt, 32'd0);
      if (sel) qB.delete();
      else     qA.delete();
      modelCnt[sel] = 0;
      held[sel]     = 1'b0;
    end else begin
      checkEq({tag, "_req_ready"}, 32'(rr), 32'(!v));
      checkEq({tag, "_word_cnt"}, cnt, 32'(modelCnt[sel]));
      if (held[sel]) begin
        checkEq({tag, "_hold_valid"}, 32'(v), 32'd1);
        checkEq({tag, "_hold_instr"}, act.instr, heldWord[sel].instr);
        checkEq({tag, "_hold_err_last"}, {30'd0, act.err, act.last},
                {30'd0, heldWord[sel].err, heldWord[sel].last});
      end
      held[sel] = 1'b0;
      if (rst_n && v) begin
        if (outReady) begin
          if ((sel ? qB.size() : qA.size()) == 0) begin
            nCompared++;
            nFailed++;
            $display("[TB] FAIL %s_unexpected_word: got %h, expected no output", tag, act.instr);
          end else begin
            if (sel) e = qB.pop_front();
            else     e = qA.pop_front();
            checkEq({tag, "_instr"}, act.instr, e.instr);
            checkEq({tag, "_err_last"}, {30'd0, act.err, act.last}, {30'd0, e.err, e.last});
          end
          if (modelCnt[sel] < satMax[sel]) modelCnt[sel]++;
        end else begin
          held[sel]     = 1'b1;
          heldWord[sel] = act;
        end
      end
    end
  endtask

  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (qA.size() == 0 && qB.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nCompared++;
      nFailed++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d words pending, expected 0", qA.size(), qB.size());
    end
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [31:0] randImm();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom());
      1:       v = int'($urandom_range(0, 8191)) - 4096;
      2:       v = int'($urandom() & 32'hfffff000) | int'($urandom_range(0, 1) * $urandom_range(0, 4095));
      default: v = int'($urandom_range(0, 1 << 22)) - (1 << 21);
    endcase
    if ($urandom_range(0, 1) == 1) v = v & ~1;
    return 32'(v);
  endfunction

  // Monitor: sample the reset state at each edge, then inspect outputs on
  // the falling edge, well away from the active edge.
  initial begin
    bit rstEdge;
    forever begin
      @(posedge clk);
      rstEdge = !rst_n;
      @(negedge clk);
      checkOutput(1'b0, rstEdge);
      checkOutput(1'b1, rstEdge);
    end
  end

  // Consumer: forced stalls first, then either always-ready or random.
  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stallLeft > 0) begin
        outReady = 1'b0;
        stallLeft--;
      end else if (randReady) begin
        outReady = ($urandom_range(0, 3) != 0);
      end else begin
        outReady = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    reqValidA = 1'b0; reqValidB = 1'b0;
    reqFmt = '0; reqOpcode = '0; reqFunct3 = '0;
    reqRd = '0; reqRs1 = '0; reqRs2 = '0; reqImm = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(0, FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    applyStimulus(0, FMT_LI, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd42);
    applyStimulus(0, FMT_B, OPC_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    applyStimulus(0, FMT_B, OPC_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 32'd9);
    applyStimulus(0, FMT_B, OPC_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    applyStimulus(0, FMT_I, OPC_OPIMM, 3'd0, 5'd3, 5'd4, 5'd0, 32'hFFFFF800);
    applyStimulus(0, FMT_I, OPC_OPIMM, 3'd0, 5'd3, 5'd4, 5'd0, 32'd2048);
    applyStimulus(0, FMT_U, OPC_LUI, 3'd0, 5'd6, 5'd0, 5'd0, 32'h00001001);
    applyStimulus(0, 3'd6, OPC_OPIMM, 3'd0, 5'd6, 5'd0, 5'd0, 32'h0);
    applyStimulus(0, FMT_LI, 7'd0, 3'd0, 5'd8, 5'd0, 5'd0, 32'h12345000);
    applyStimulus(0, FMT_LI, 7'd0, 3'd0, 5'd9, 5'd0, 5'd0, 32'h0);
    applyStimulus(0, FMT_J, OPC_JAL, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFF00000);
    applyStimulus(1, FMT_LI, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd42);
    applyStimulus(1, FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    waitDrain();

    $display("[TB] LI under backpressure");
    stallLeft = 6;
    applyStimulus(0, FMT_LI, 7'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'hDEADBEEF);
    waitDrain();

    $display("[TB] reset between LUI and ADDI");
    applyStimulus(0, FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(0, FMT_S, OPC_STORE, 3'd2, 5'd0, 5'd10, 5'd11, 32'hFFFFFFFC);
    waitDrain();

    $display("[TB] random traffic");
    randReady = 1'b1;
    for (int k = 0; k < 150; k++) begin
      applyStimulus(0, 3'($urandom_range(0, 7)), opcTable[$urandom_range(0, 7)],
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), randImm());
    end
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1, 3'($urandom_range(0, 7)), opcTable[$urandom_range(0, 7)],
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), randImm());
    end
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
